// File: rtl/uart_tx_ctrl_if.sv
// UART transmit controller handshake bundle.
// Parallel request side plus serial line and busy flag.
interface uart_tx_ctrl_if #(
  parameter int Data_WD = 8
);
  logic [Data_WD-1:0] P_DATA;
  logic               Data_Valid;
  logic               PAR_EN;
  logic               par_bit;
  logic               TX_OUT;
  logic               busy;

  modport master (
    output P_DATA,
    output Data_Valid,
    output PAR_EN,
    output par_bit,
    input  TX_OUT,
    input  busy
  );

  modport slave (
    input  P_DATA,
    input  Data_Valid,
    input  PAR_EN,
    input  par_bit,
    output TX_OUT,
    output busy
  );
endinterface

// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: start/data/parity/stop framing.
// One bit per baud clock, LSB first, registered outputs.
module uart_tx_ctrl #(
  parameter int Data_WD = 8
) (
  input  logic           CLK,
  input  logic           RST,
  uart_tx_ctrl_if.slave  bus
);

  localparam int CW = (Data_WD > 1) ? $clog2(Data_WD) : 1;
  localparam logic [CW-1:0] LAST = CW'(Data_WD - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t             state, state_d;
  logic [Data_WD-1:0] sh, sh_d;
  logic [CW-1:0]      cnt, cnt_d;
  logic               pen, pen_d;
  logic               tx_q, tx_d;
  logic               busy_q, busy_d;
  logic               accept;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state  <= IDLE;
      sh     <= '0;
      cnt    <= '0;
      pen    <= 1'b0;
      tx_q   <= 1'b1;
      busy_q <= 1'b0;
    end else begin
      state  <= state_d;
      sh     <= sh_d;
      cnt    <= cnt_d;
      pen    <= pen_d;
      tx_q   <= tx_d;
      busy_q <= busy_d;
    end
  end

  always_comb begin
    state_d = state;
    sh_d    = sh;
    cnt_d   = cnt;
    pen_d   = pen;
    tx_d    = 1'b1;
    busy_d  = 1'b0;
    accept  = bus.Data_Valid &&
              (state == IDLE || state == STOP);

    unique case (state)
      IDLE, STOP: begin
        if (accept) begin
          state_d = START;
          sh_d    = bus.P_DATA;
          pen_d   = bus.PAR_EN;
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        state_d = DATA;
        cnt_d   = '0;
      end
      DATA: begin
        sh_d  = sh >> 1;
        cnt_d = cnt + CW'(1);
        if (cnt == LAST)
          state_d = pen ? PARITY : STOP;
      end
      PARITY: state_d = STOP;
      default: state_d = IDLE;
    endcase

    // Outputs are derived from the next state so they register with it.
    unique case (state_d)
      START: begin
        tx_d   = 1'b0;
        busy_d = 1'b1;
      end
      DATA: begin
        tx_d   = sh_d[0];
        busy_d = 1'b1;
      end
      PARITY: begin
        tx_d   = bus.par_bit;
        busy_d = 1'b1;
      end
      default: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
      end
    endcase
  end

  assign bus.TX_OUT = tx_q;
  assign bus.busy   = busy_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl: frame-queue model, directed and random frames.
module tb_uart_tx_ctrl;

  localparam int WD = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  uart_tx_ctrl_if #(.Data_WD(WD)) bus ();

  uart_tx_ctrl #(.Data_WD(WD)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int   vectors = 0;
  int   miscompares = 0;
  logic exp_tx = 1'b1;
  logic exp_busy = 1'b0;
  logic qtx[$];
  logic qbusy[$];
  logic [31:0] cap;
  int   bcnt;

  task automatic push_frame(input logic [WD-1:0] d,
                            input logic pe,
                            input logic pb);
    qtx.push_back(1'b0);
    qbusy.push_back(1'b1);
    for (int i = 0; i < WD; i++) begin
      qtx.push_back(d[i]);
      qbusy.push_back(1'b1);
    end
    if (pe) begin
      qtx.push_back(pb);
      qbusy.push_back(1'b1);
    end
    qtx.push_back(1'b1);
    qbusy.push_back(1'b0);
  endtask

  task automatic model_reset();
    qtx.delete();
    qbusy.delete();
    exp_tx = 1'b1;
    exp_busy = 1'b0;
  endtask

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h",
               name, act, req);
    end
  endtask

  task automatic step(input logic dv,
                      input logic [WD-1:0] d,
                      input logic pe);
    bus.Data_Valid = dv;
    bus.P_DATA = d;
    bus.PAR_EN = pe;
    @(posedge clk);
    if (rst) begin
      if (dv && !exp_busy)
        push_frame(d, pe, bus.par_bit);
      if (qtx.size() > 0) begin
        exp_tx = qtx.pop_front();
        exp_busy = qbusy.pop_front();
      end else begin
        exp_tx = 1'b1;
        exp_busy = 1'b0;
      end
    end
    @(negedge clk);
  endtask

  task automatic grab();
    cap = {cap[30:0], bus.TX_OUT};
    if (bus.busy) bcnt++;
  endtask

  task automatic idle_step();
    step(1'b0, WD'($urandom), 1'($urandom));
  endtask

  always @(negedge clk) begin
    vectors++;
    if (bus.TX_OUT !== exp_tx || bus.busy !== exp_busy) begin
      miscompares++;
      $display("FAIL cycle @%0t: tx=%b busy=%b, expected tx=%b busy=%b",
               $time, bus.TX_OUT, bus.busy, exp_tx, exp_busy);
    end
  end

  initial begin
    bus.Data_Valid = 1'b0;
    bus.P_DATA = '0;
    bus.PAR_EN = 1'b0;
    bus.par_bit = 1'b0;
    #1 rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      bus.par_bit = 1'($urandom);
      step(1'($urandom), WD'($urandom), 1'($urandom));
    end
    check("reset_tx", 32'(bus.TX_OUT), 32'd1);
    check("reset_busy", 32'(bus.busy), 32'd0);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) idle_step();
    check("idle_tx", 32'(bus.TX_OUT), 32'd1);

    // even-parity frame 0xA5
    cap = '0; bcnt = 0;
    bus.par_bit = 1'b0;
    step(1'b1, 8'hA5, 1'b1); grab();
    for (int i = 0; i < 10; i++) begin
      idle_step(); grab();
    end
    check("a5_bits", cap & 32'h7FF, 32'b01010010101);
    check("a5_busy", 32'(bcnt), 32'd10);
    idle_step();
    check("a5_idle", 32'(bus.TX_OUT), 32'd1);

    // no-parity frame 0x3C
    cap = '0; bcnt = 0;
    step(1'b1, 8'h3C, 1'b0); grab();
    for (int i = 0; i < 9; i++) begin
      idle_step(); grab();
    end
    check("3c_bits", cap & 32'h3FF, 32'b0001111001);
    check("3c_busy", 32'(bcnt), 32'd9);
    for (int i = 0; i < 2; i++) idle_step();

    // back-to-back 0x01 then 0x80 in STOP
    cap = '0; bcnt = 0;
    step(1'b1, 8'h01, 1'b0); grab();
    for (int i = 0; i < 9; i++) begin
      idle_step(); grab();
    end
    step(1'b1, 8'h80, 1'b0); grab();
    for (int i = 0; i < 9; i++) begin
      idle_step(); grab();
    end
    check("b2b_bits", cap & 32'hFFFFF,
          32'b01000000010000000011);
    check("b2b_busy", 32'(bcnt), 32'd18);
    for (int i = 0; i < 2; i++) idle_step();

    // request during DATA must be ignored
    cap = '0; bcnt = 0;
    step(1'b1, 8'h00, 1'b0); grab();
    for (int i = 0; i < 9; i++) begin
      step(i == 3, 8'hFF, 1'b1); grab();
    end
    check("ign_bits", cap & 32'h3FF, 32'b0000000001);
    check("ign_busy", 32'(bcnt), 32'd9);
    for (int i = 0; i < 4; i++) idle_step();
    check("ign_noframe", 32'(bus.busy), 32'd0);

    // reset during data bit 3
    step(1'b1, 8'h5A, 1'b1);
    for (int i = 0; i < 4; i++) idle_step();
    #2 rst = 1'b0;
    #1;
    check("rst_mid_tx", 32'(bus.TX_OUT), 32'd1);
    check("rst_mid_busy", 32'(bus.busy), 32'd0);
    model_reset();
    @(negedge clk);
    idle_step();
    rst = 1'b1;
    cap = '0; bcnt = 0;
    bus.par_bit = 1'b1;
    step(1'b1, 8'hC3, 1'b1); grab();
    for (int i = 0; i < 10; i++) begin
      idle_step(); grab();
    end
    check("post_rst_bits", cap & 32'h7FF, 32'b01100001111);
    check("post_rst_busy", 32'(bcnt), 32'd10);

    // random traffic, mid-frame input noise
    for (int i = 0; i < 600; i++) begin
      logic dv;
      dv = ($urandom_range(0, 3) == 0);
      if (dv && !exp_busy) bus.par_bit = 1'($urandom);
      step(dv, WD'($urandom), 1'($urandom));
    end
    for (int i = 0; i < 12; i++) idle_step();

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
